// File: rtl/cond_logic_mctx.sv
// Conditional-execution unit: per-context NZCV flag banks and IT-block sequencers,
// gating PCSrc/RegWrite/MemWrite and flag writes on the evaluated condition.
module cond_logic_mctx #(
   parameter int unsigned NCTX = 2,
   parameter bit          ITEN = 1'b1,
   localparam int unsigned CW  = (NCTX > 1) ? $clog2(NCTX) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          Valid,
   input  logic          Stall,
   input  logic [CW-1:0] Ctx,
   input  logic [3:0]    Cond,
   input  logic [3:0]    ALUFlags,
   input  logic [1:0]    FlagW,
   input  logic          PCS,
   input  logic          RegW,
   input  logic          MemW,
   input  logic          ITStart,
   input  logic [3:0]    ITCond,
   input  logic [3:0]    ITMask,
   output logic          CondEx,
   output logic          PCSrc,
   output logic          RegWrite,
   output logic          MemWrite,
   output logic          InIT,
   output logic [3:0]    FlagsOut
);

   logic [3:0] flags [NCTX];
   logic [7:0] its   [NCTX];

   logic          ctx_ok;
   logic [CW-1:0] idx;
   logic [3:0]    cur_flags;
   logic [7:0]    cur_its;
   logic [7:0]    its_nxt;
   logic          act, it_act, it_load, it_adv;
   logic [3:0]    ec;
   logic          n, z, c, v, ge, pass, go;

   // Out-of-range contexts read as all-zero state and never update.
   assign ctx_ok    = ({{(32-CW){1'b0}}, Ctx} < NCTX);
   assign idx       = ctx_ok ? Ctx : '0;
   assign cur_flags = ctx_ok ? flags[idx] : '0;
   assign cur_its   = ctx_ok ? its[idx]   : '0;

   assign act     = Valid & ~Stall & ctx_ok;
   assign it_act  = ITEN & (cur_its[3:0] != 4'b0000);
   assign it_load = act & ITEN & ITStart & ~it_act & (ITMask != 4'b0000);
   assign it_adv  = act & it_act & ~it_load;

   assign ec = it_act ? cur_its[7:4] : Cond;
   assign {n, z, c, v} = cur_flags;
   assign ge = (n == v);

   always_comb begin
      pass = 1'b0;
      unique case (ec)
         4'b0000: pass = z;
         4'b0001: pass = ~z;
         4'b0010: pass = c;
         4'b0011: pass = ~c;
         4'b0100: pass = n;
         4'b0101: pass = ~n;
         4'b0110: pass = v;
         4'b0111: pass = ~v;
         4'b1000: pass = c & ~z;
         4'b1001: pass = ~(c & ~z);
         4'b1010: pass = ge;
         4'b1011: pass = ~ge;
         4'b1100: pass = ~z & ge;
         4'b1101: pass = ~(~z & ge);
         4'b1110: pass = 1'b1;
         4'b1111: pass = 1'b0;
      endcase
   end

   assign go       = act & pass;
   assign CondEx   = go;
   assign PCSrc    = PCS & go;
   assign RegWrite = RegW & go;
   assign MemWrite = MemW & go;
   assign InIT     = it_act & ctx_ok;
   assign FlagsOut = cur_flags;

   // Advance shifts only [4:0]; the base condition bits [7:5] stay fixed.
   always_comb begin
      its_nxt = cur_its;
      if (it_load)
         its_nxt = {ITCond, ITMask};
      else if (it_adv)
         its_nxt = (cur_its[2:0] == 3'b000) ? 8'h00 : {cur_its[7:5], cur_its[3:0], 1'b0};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned k = 0; k < NCTX; k++) begin
            flags[k] <= '0;
            its[k]   <= '0;
         end
      end else if (act) begin
         for (int unsigned k = 0; k < NCTX; k++) begin
            if (CW'(k) == idx) begin
               if (go && FlagW[1]) flags[k][3:2] <= ALUFlags[3:2];
               if (go && FlagW[0]) flags[k][1:0] <= ALUFlags[1:0];
               its[k] <= its_nxt;
            end
         end
      end
   end

endmodule

// File: tb/tb_cond_logic_mctx.sv
// Scoreboard bench for cond_logic_mctx: expected outputs are queued as each
// instruction is driven and compared once the combinational outputs settle.
module tb_cond_logic_mctx;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       Valid = 1'b0, Stall = 1'b0;
   logic [1:0] Ctx = '0;
   logic [3:0] Cond = 4'b1110, ALUFlags = '0;
   logic [1:0] FlagW = '0;
   logic       PCS = 1'b0, RegW = 1'b0, MemW = 1'b0, ITStart = 1'b0;
   logic [3:0] ITCond = '0, ITMask = '0;
   logic       CondEx, PCSrc, RegWrite, MemWrite, InIT;
   logic [3:0] FlagsOut;

   int checks = 0;
   int errors = 0;

   // exp = {CondEx, PCSrc, RegWrite, MemWrite, InIT, FlagsOut}
   typedef struct packed {
      logic       v, st;
      logic [1:0] ctx;
      logic [3:0] cond, alu;
      logic [1:0] fw;
      logic       pcs, regw, memw, its;
      logic [3:0] itc, itm;
      logic [8:0] exp;
   } stim_t;

   logic [8:0] sb [$];
   logic [8:0] got, e;

   cond_logic_mctx #(.NCTX(3), .ITEN(1'b1)) dut (
      .clk(clk), .reset(reset), .Valid(Valid), .Stall(Stall), .Ctx(Ctx),
      .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW),
      .MemW(MemW), .ITStart(ITStart), .ITCond(ITCond), .ITMask(ITMask),
      .CondEx(CondEx), .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
      .InIT(InIT), .FlagsOut(FlagsOut)
   );

   always #5 clk = ~clk;

   assign got = {CondEx, PCSrc, RegWrite, MemWrite, InIT, FlagsOut};

   function automatic stim_t mk(input logic v, input logic st, input logic [1:0] ctx,
                                input logic [3:0] cond, input logic [3:0] alu,
                                input logic [1:0] fw, input logic pcs, input logic regw,
                                input logic memw, input logic its, input logic [3:0] itc,
                                input logic [3:0] itm, input logic [8:0] exp);
      mk = '{v, st, ctx, cond, alu, fw, pcs, regw, memw, its, itc, itm, exp};
   endfunction

   task automatic drive(input stim_t s);
      @(negedge clk);
      Valid = s.v; Stall = s.st; Ctx = s.ctx; Cond = s.cond; ALUFlags = s.alu;
      FlagW = s.fw; PCS = s.pcs; RegW = s.regw; MemW = s.memw; ITStart = s.its;
      ITCond = s.itc; ITMask = s.itm;
      sb.push_back(s.exp);
   endtask

   task automatic test_reset();
      sb.push_back(9'b0000_0_0000);
      #1;
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL reset: got %b expected %b", got, e);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_flags();
      stim_t q[$];
      q.push_back(mk(1'b1,1'b0,2'd0,4'b1110,4'b0100,2'b11,1'b0,1'b0,1'b0,1'b0,4'h0,4'h0,9'b1000_0_0000));
      q.push_back(mk(1'b1,1'b0,2'd0,4'b0000,4'b0000,2'b00,1'b0,1'b1,1'b0,1'b0,4'h0,4'h0,9'b1010_0_0100));
      q.push_back(mk(1'b1,1'b0,2'd0,4'b0001,4'b0000,2'b00,1'b0,1'b1,1'b0,1'b0,4'h0,4'h0,9'b0000_0_0100));
      q.push_back(mk(1'b1,1'b0,2'd0,4'b1111,4'b0000,2'b00,1'b1,1'b1,1'b1,1'b0,4'h0,4'h0,9'b0000_0_0100));
      q.push_back(mk(1'b1,1'b0,2'd0,4'b1110,4'b0000,2'b00,1'b1,1'b0,1'b1,1'b0,4'h0,4'h0,9'b1101_0_0100));
      q.push_back(mk(1'b1,1'b0,2'd0,4'b1110,4'b0000,2'b11,1'b0,1'b0,1'b0,1'b0,4'h0,4'h0,9'b1000_0_0100));
      q.push_back(mk(1'b1,1'b0,2'd0,4'b0000,4'b1111,2'b11,1'b0,1'b0,1'b0,1'b0,4'h0,4'h0,9'b0000_0_0000));
      q.push_back(mk(1'b0,1'b0,2'd0,4'b1110,4'b0000,2'b00,1'b0,1'b0,1'b0,1'b0,4'h0,4'h0,9'b0000_0_0000));
      q.push_back(mk(1'b1,1'b0,2'd0,4'b1110,4'b1111,2'b01,1'b0,1'b0,1'b0,1'b0,4'h0,4'h0,9'b1000_0_0000));
      q.push_back(mk(1'b0,1'b0,2'd0,4'b1110,4'b0000,2'b00,1'b0,1'b0,1'b0,1'b0,4'h0,4'h0,9'b0000_0_0011));
      q.push_back(mk(1'b1,1'b0,2'd0,4'b1000,4'b0000,2'b00,1'b0,1'b0,1'b0,1'b0,4'h0,4'h0,9'b1000_0_0011));
      q.push_back(mk(1'b1,1'b0,2'd0,4'b1010,4'b0000,2'b00,1'b0,1'b0,1'b0,1'b0,4'h0,4'h0,9'b0000_0_0011));
      q.push_back(mk(1'b1,1'b0,2'd0,4'b1101,4'b0000,2'b00,1'b0,1'b0,1'b0,1'b0,4'h0,4'h0,9'b1000_0_0011));
      for (int i = 0; i < q.size(); i++) begin
         drive(q[i]);
         #2;
         e = sb.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL flags[%0d]: got %b expected %b", i, got, e);
         end
      end
   endtask

   task automatic test_ctx();
      stim_t q[$];
      q.push_back(mk(1'b1,1'b0,2'd1,4'b1110,4'b1000,2'b11,1'b0,1'b0,1'b0,1'b0,4'h0,4'h0,9'b1000_0_0000));
      q.push_back(mk(1'b1,1'b0,2'd1,4'b1011,4'b0000,2'b00,1'b0,1'b0,1'b0,1'b0,4'h0,4'h0,9'b1000_0_1000));
      q.push_back(mk(1'b1,1'b0,2'd2,4'b1011,4'b0000,2'b00,1'b0,1'b0,1'b0,1'b0,4'h0,4'h0,9'b0000_0_0000));
      q.push_back(mk(1'b0,1'b0,2'd0,4'b1110,4'b0000,2'b00,1'b0,1'b0,1'b0,1'b0,4'h0,4'h0,9'b0000_0_0011));
      q.push_back(mk(1'b1,1'b0,2'd3,4'b1110,4'b1111,2'b11,1'b1,1'b1,1'b1,1'b1,4'h0,4'hF,9'b0000_0_0000));
      q.push_back(mk(1'b0,1'b0,2'd1,4'b1110,4'b0000,2'b00,1'b0,1'b0,1'b0,1'b0,4'h0,4'h0,9'b0000_0_1000));
      q.push_back(mk(1'b0,1'b0,2'd2,4'b1110,4'b0000,2'b00,1'b0,1'b0,1'b0,1'b0,4'h0,4'h0,9'b0000_0_0000));
      q.push_back(mk(1'b1,1'b1,2'd0,4'b1110,4'b0100,2'b11,1'b1,1'b1,1'b1,1'b0,4'h0,4'h0,9'b0000_0_0011));
      q.push_back(mk(1'b0,1'b0,2'd0,4'b1110,4'b0000,2'b00,1'b0,1'b0,1'b0,1'b0,4'h0,4'h0,9'b0000_0_0011));
      for (int i = 0; i < q.size(); i++) begin
         drive(q[i]);
         #2;
         e = sb.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL ctx[%0d]: got %b expected %b", i, got, e);
         end
      end
   endtask

   task automatic test_it();
      stim_t q[$];
      q.push_back(mk(1'b1,1'b0,2'd0,4'b1110,4'b0100,2'b11,1'b0,1'b0,1'b0,1'b0,4'h0,4'h0,9'b1000_0_0011));
      q.push_back(mk(1'b1,1'b0,2'd0,4'b1110,4'b0000,2'b00,1'b0,1'b0,1'b0,1'b1,4'b0000,4'b1010,9'b1000_0_0100));
      q.push_back(mk(1'b1,1'b0,2'd0,4'b1110,4'b0000,2'b00,1'b0,1'b1,1'b0,1'b0,4'h0,4'h0,9'b1010_1_0100));
      q.push_back(mk(1'b1,1'b1,2'd0,4'b1110,4'b0000,2'b00,1'b0,1'b1,1'b0,1'b0,4'h0,4'h0,9'b0000_1_0100));
      q.push_back(mk(1'b1,1'b0,2'd0,4'b1110,4'b0000,2'b00,1'b0,1'b1,1'b0,1'b0,4'h0,4'h0,9'b0000_1_0100));
      q.push_back(mk(1'b1,1'b0,2'd0,4'b1110,4'b0000,2'b00,1'b0,1'b1,1'b0,1'b0,4'h0,4'h0,9'b1010_1_0100));
      q.push_back(mk(1'b1,1'b0,2'd0,4'b1110,4'b0000,2'b00,1'b0,1'b1,1'b0,1'b0,4'h0,4'h0,9'b1010_0_0100));
      q.push_back(mk(1'b1,1'b0,2'd0,4'b1110,4'b0000,2'b00,1'b0,1'b0,1'b0,1'b1,4'b0001,4'b0000,9'b1000_0_0100));
      q.push_back(mk(1'b1,1'b0,2'd0,4'b1110,4'b0000,2'b00,1'b0,1'b1,1'b0,1'b0,4'h0,4'h0,9'b1010_0_0100));
      q.push_back(mk(1'b1,1'b0,2'd0,4'b1110,4'b0000,2'b00,1'b0,1'b0,1'b0,1'b1,4'b0001,4'b1000,9'b1000_0_0100));
      q.push_back(mk(1'b1,1'b0,2'd0,4'b1110,4'b0000,2'b00,1'b0,1'b1,1'b0,1'b1,4'b0000,4'b1111,9'b0000_1_0100));
      q.push_back(mk(1'b1,1'b0,2'd0,4'b1110,4'b0000,2'b00,1'b0,1'b1,1'b0,1'b0,4'h0,4'h0,9'b1010_0_0100));
      q.push_back(mk(1'b1,1'b0,2'd0,4'b0001,4'b0000,2'b00,1'b0,1'b0,1'b0,1'b1,4'b0001,4'b1000,9'b0000_0_0100));
      q.push_back(mk(1'b1,1'b0,2'd0,4'b1110,4'b0000,2'b00,1'b0,1'b1,1'b0,1'b0,4'h0,4'h0,9'b0000_1_0100));
      q.push_back(mk(1'b1,1'b0,2'd0,4'b1110,4'b0000,2'b00,1'b0,1'b1,1'b0,1'b0,4'h0,4'h0,9'b1010_0_0100));
      for (int i = 0; i < q.size(); i++) begin
         drive(q[i]);
         #2;
         e = sb.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL it[%0d]: got %b expected %b", i, got, e);
         end
      end
   endtask

   task automatic test_async_reset();
      stim_t q[$];
      stim_t p[$];
      q.push_back(mk(1'b1,1'b0,2'd0,4'b1110,4'b0000,2'b00,1'b0,1'b0,1'b0,1'b1,4'b0000,4'b1010,9'b1000_0_0100));
      q.push_back(mk(1'b1,1'b0,2'd0,4'b1110,4'b0000,2'b00,1'b0,1'b1,1'b0,1'b0,4'h0,4'h0,9'b1010_1_0100));
      q.push_back(mk(1'b0,1'b0,2'd0,4'b1110,4'b0000,2'b00,1'b0,1'b0,1'b0,1'b0,4'h0,4'h0,9'b0000_1_0100));
      for (int i = 0; i < q.size(); i++) begin
         drive(q[i]);
         #2;
         e = sb.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL rst_pre[%0d]: got %b expected %b", i, got, e);
         end
      end
      #1;
      reset = 1'b0;
      sb.push_back(9'b0000_0_0000);
      #1;
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL rst_async: got %b expected %b", got, e);
      end
      @(negedge clk);
      reset = 1'b1;
      p.push_back(mk(1'b1,1'b0,2'd0,4'b0000,4'b0000,2'b00,1'b0,1'b1,1'b0,1'b0,4'h0,4'h0,9'b0000_0_0000));
      p.push_back(mk(1'b0,1'b0,2'd1,4'b1110,4'b0000,2'b00,1'b0,1'b0,1'b0,1'b0,4'h0,4'h0,9'b0000_0_0000));
      for (int i = 0; i < p.size(); i++) begin
         drive(p[i]);
         #2;
         e = sb.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL rst_post[%0d]: got %b expected %b", i, got, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_flags();
      test_ctx();
      test_it();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cond_logic_mctx.md
Name: cond_logic_mctx

Overview:
Parametrised conditional-execution unit for the ARM datapath. It keeps NCTX independent NZCV flag banks, one per hardware context. It also keeps one Thumb-style IT-block sequencer (ITSTATE) per context. Each cycle it evaluates the condition of the issuing instruction against its context's flags, and gates PCSrc, RegWrite and MemWrite plus that context's flag writes.

Parameters:
NCTX, 2, number of flag/ITSTATE contexts (1..16); CW = max(1, clog2(NCTX)) is derived.
ITEN, 1, 1 = IT-block support present; 0 = ITStart ignored and InIT tied 0.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low; clears all state
Valid  in  1  instruction present this cycle
Stall  in  1  pipeline hold; no state update, outputs gated off
Ctx  in  CW  context of the current instruction
Cond  in  4  instruction condition field
ALUFlags  in  4  {N,Z,C,V} from the ALU
FlagW  in  2  [1] writes N,Z; [0] writes C,V
PCS  in  1  instruction writes PC
RegW  in  1  instruction writes a register
MemW  in  1  instruction writes memory
ITStart  in  1  current instruction is an IT
ITCond  in  4  IT firstcond
ITMask  in  4  IT mask
CondEx  out  1  condition passed, gated
PCSrc  out  1  PCS & go
RegWrite  out  1  RegW & go
MemWrite  out  1  MemW & go
InIT  out  1  Ctx currently inside an IT block
FlagsOut  out  4  registered flags of Ctx

Behaviour:
- State per context c:
  - Flags[c][3:0], {N,Z,C,V}.
  - ITS[c][7:0].
  - Both are 0 on reset. Reset is asynchronous: all outputs that depend on state drop immediately.
- CtxOK = Ctx < NCTX. Act = Valid & ~Stall & CtxOK.
- Outputs are purely combinational from inputs and current state, so latency is 0. Flag and ITSTATE updates appear on the next rising edge.
- Active IT block: ITact = ITEN & (ITS[Ctx][3:0] != 0). InIT = ITact & CtxOK.
- Effective condition: EC = ITact ? ITS[Ctx][7:4] : Cond.
- Condition evaluation against Flags[Ctx], with ge = (N==V):
  - 0000 Z; 0001 ~Z; 0010 C; 0011 ~C
  - 0100 N; 0101 ~N; 0110 V; 0111 ~V
  - 1000 C&~Z; 1001 ~(C&~Z)
  - 1010 ge; 1011 ~ge
  - 1100 ~Z&ge; 1101 ~(~Z&ge)
  - 1110 1; 1111 0 (never x)
- go = Act & pass.
  - CondEx = go.
  - PCSrc = PCS&go; RegWrite = RegW&go; MemWrite = MemW&go.
- If Act=0, all of CondEx, PCSrc, RegWrite and MemWrite are 0.
- Flag write: on an edge with go=1:
  - FlagW[1] loads ALUFlags[3:2] into Flags[Ctx][3:2].
  - FlagW[0] loads ALUFlags[1:0] into Flags[Ctx][1:0].
  - Other contexts are untouched.
- Flags take effect the next cycle. There is no same-cycle bypass.
- IT start: Act & ITEN & ITStart & ~ITact & (ITMask != 0) loads ITS[Ctx] = {ITCond, ITMask}.
  - The IT itself evaluates using Cond as normal.
  - ITS loads even if the IT's own pass=0.
- ITMask = 0000 means ITS is unchanged (NOP).
- ITStart while ITact: treated as an ordinary conditional instruction that consumes one slot. No reload.
- IT advance: each Act instruction with ITact and no load advances ITS[Ctx], whether it passed or not.
  - If ITS[2:0] == 000: ITS becomes 0, and the block ends.
  - Else: ITS[4:0] = ITS[4:0] << 1, and ITS[7:5] is held.
- Maximum block length is 4 instructions.
- Stall=1 or Valid=0: no update to any context.
- Ctx >= NCTX: outputs 0, InIT 0, FlagsOut 0, no update.
- Reset asserted mid IT block: the block is abandoned and all contexts return to the non-IT state.

Test Plan:
- Flag write then use:
  - Reset. Ctx0, Cond=1110, FlagW=11, ALUFlags=0100 → next cycle FlagsOut=0100.
  - Then Cond=0000, RegW=1 → RegWrite=1. Cond=0001 → RegWrite=0.
- Context isolation (NCTX=2): Ctx1 writes 1000 (N=1, V=0). Cond=1011 → CondEx=1 on Ctx1, 0 on Ctx0 (flags 0000).
- Failed condition suppresses flag write: Ctx0 Z=0, Cond=0000, FlagW=11, ALUFlags=1111 → CondEx=0, FlagsOut stays 0000 next cycle.
- IT sequence: Z=1, ITStart with ITCond=0000, ITMask=1010. Then four RegW=1 instructions with Cond=1110:
  - Effective conditions EQ, NE, EQ → RegWrite 1,0,1, InIT 1,1,1.
  - 4th instruction → InIT=0, RegWrite=1.
  - Stall=1 inserted at slot 2 → outputs 0, sequence resumes unchanged.
- Async reset mid-block: after the IT load and one slot, drive reset=0 between edges → InIT=0 and FlagsOut=0000 immediately. After release, Cond=0000 with Z=0 → CondEx=0.
- Edge cases:
  - Cond=1111 → CondEx=0.
  - ITMask=0000 → InIT stays 0.
  - Ctx=2 with NCTX=2 → all outputs 0, no state change.
